inference_sequencer: RTL
========================

Name: inference_sequencer

Overview:
- Controller that sequences the binary-image classifier after the pixel filter has filled the image store.
- On each new `image_ready` rising edge it walks every pixel once per output class.
- It drives a single shared MAC unit through a valid/ready handshake, collects each class accumulator and tracks the argmax.
- It reports the winning class index and the winning score.

Parameters:
IMG_ROWS, 28, image rows (row index range 0..IMG_ROWS-1)
IMG_COLS, 28, image columns
NUM_CLASSES, 10, output neurons evaluated sequentially
ACC_W, 16, signed accumulator width from MAC
WADDR_W, 14, weight address width; must satisfy 2^WADDR_W >= NUM_CLASSES*IMG_ROWS*IMG_COLS

Ports:
fpga_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
image_ready  in  1  level from image capture; a rising edge starts inference, low aborts it
pix_row  out  $clog2(IMG_ROWS)  row of pixel currently addressed
pix_col  out  $clog2(IMG_COLS)  column of pixel currently addressed
pix_bit  in  1  filtered pixel at (pix_row, pix_col), combinational from image store
weight_addr  out  WADDR_W  class*IMG_ROWS*IMG_COLS + row*IMG_COLS + col
mac_clear  out  1  one-cycle pulse zeroing the MAC accumulator
mac_valid  out  1  MAC transaction valid
mac_bit  out  1  pixel operand, equals pix_bit
mac_ready  in  1  MAC accepts transaction when mac_valid && mac_ready
acc_valid  in  1  one-cycle pulse: acc_in holds final sum for current class
acc_in  in  ACC_W  signed accumulator result
class_idx  out  $clog2(NUM_CLASSES)  class currently being evaluated
busy  out  1  high in any state other than IDLE
result_class  out  $clog2(NUM_CLASSES)  argmax of last completed inference
result_score  out  ACC_W  winning accumulator value (signed)
result_valid  out  1  one-cycle pulse when result_* update

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Internal best score = most negative ACC_W value; edge-detect register 0.
- Start trigger: `image_ready` registered each cycle; start is `image_ready && !image_ready_q` while in IDLE.
  - A level held high does not retrigger.
- States:
  - IDLE: waits for start. On start, go to CLEAR with class_idx=0, row=0, col=0, best=min, best_idx=0.
  - CLEAR: assert mac_clear for exactly one cycle, then go to FEED.
  - FEED:
    - mac_valid=1 with mac_bit=pix_bit and weight_addr per formula, all combinational from registered row/col/class_idx.
    - On handshake, advance: col++, wrapping to 0 with row++ at IMG_COLS-1.
    - Handshake on the pixel (IMG_ROWS-1, IMG_COLS-1) goes to DRAIN.
    - mac_valid stays high while mac_ready is low; address and bit must remain stable.
  - DRAIN: mac_valid=0. Wait for acc_valid, then go to COMPARE.
    - No timeout. acc_valid seen in FEED is ignored.
  - COMPARE (one cycle): if acc_in > best (signed), then best=acc_in, best_idx=class_idx. Ties keep the lower index.
    - If class_idx == NUM_CLASSES-1, go to DONE.
    - Otherwise class_idx++, row=col=0, go to CLEAR.
  - DONE (one cycle): result_class=best_idx, result_score=best, result_valid=1, then go to IDLE.
- Throughput: with mac_ready tied high, one pixel per cycle.
  - Cycles per class = 1 (CLEAR) + IMG_ROWS*IMG_COLS + DRAIN wait + 1 (COMPARE).
- Abort: image_ready low in any non-IDLE state means next state IDLE.
  - mac_valid drops that cycle; result_* unchanged; no result_valid.
- result_class and result_score hold their values until the next DONE or reset.
- Reset asserted mid-operation: immediate return to reset values, including result_*.

Optional Feature:
- Macro: `SKIP_ZERO_EN`.
- Defined:
  - In FEED, pixels with pix_bit=0 issue no transaction (mac_valid=0) and advance in one cycle without waiting for mac_ready. Binary input times weight contributes nothing.
  - The last pixel being 0 still goes to DRAIN.
  - An all-zero class issues only mac_clear; the MAC must still pulse acc_valid.
- Not defined: every pixel issues a transaction and mac_bit may be 0.

Test Plan (IMG_ROWS=2, IMG_COLS=3, NUM_CLASSES=3, ACC_W=8):
- Reset, mac_ready=1, raise image_ready; MAC model returns acc 5, 12, -3 -> exactly 3 mac_clear pulses; 18 handshakes with weight_addr 0..17 in order; result_class=1, result_score=12, single result_valid pulse.
- Same run with acc 7, 7, 7 -> result_class=0, result_score=7 (tie keeps lowest index).
- Toggle mac_ready 0/1 every cycle -> mac_valid/weight_addr held stable while not ready; still 18 handshakes; same result as the first scenario.
- Drop image_ready during class 1 FEED -> busy=0 next cycle, no result_valid, prior result_* retained; a new rising edge restarts at weight_addr 0.
- Hold image_ready high after DONE for 20 cycles -> no second run (busy stays 0).
- SKIP_ZERO_EN with image bits 101010 -> 3 handshakes per class (addresses 0, 2, 4 for class 0); without the macro -> 6 per class.

Source files
------------

// File: rtl/inference_sequencer.sv
// Inference sequencer: walks the binary image once per class through a shared MAC,
// tracks the argmax and reports it. Define SKIP_ZERO_EN to skip transactions on zero pixels.
module inference_sequencer #(
    parameter int IMG_ROWS    = 28,
    parameter int IMG_COLS    = 28,
    parameter int NUM_CLASSES = 10,
    parameter int ACC_W       = 16,
    parameter int WADDR_W     = 14,
    localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1,
    localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1,
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic               fpga_clk,
    input  logic               rst_n,
    input  logic               image_ready,
    output logic [ROW_W-1:0]   pix_row,
    output logic [COL_W-1:0]   pix_col,
    input  logic               pix_bit,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               mac_clear,
    output logic               mac_valid,
    output logic               mac_bit,
    input  logic               mac_ready,
    input  logic               acc_valid,
    input  logic [ACC_W-1:0]   acc_in,
    output logic [CLS_W-1:0]   class_idx,
    output logic               busy,
    output logic [CLS_W-1:0]   result_class,
    output logic [ACC_W-1:0]   result_score,
    output logic               result_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        COMPARE,
        DONE
    } state_t;

    localparam logic [ROW_W-1:0]         ROW_LAST   = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0]         COL_LAST   = COL_W'(IMG_COLS - 1);
    localparam logic [CLS_W-1:0]         CLS_LAST   = CLS_W'(NUM_CLASSES - 1);
    localparam logic [WADDR_W-1:0]       COL_STEP   = WADDR_W'(IMG_COLS);
    localparam logic [WADDR_W-1:0]       CLASS_STEP = WADDR_W'(IMG_ROWS * IMG_COLS);
    localparam logic signed [ACC_W-1:0]  ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                    state;
    state_t                    state_nxt;
    logic                      image_ready_q;
    logic                      start;
    logic                      feed_active;
    logic                      advance;
    logic                      col_last;
    logic                      pix_last;
    logic                      class_last;
    logic [WADDR_W-1:0]        class_base;
    logic [WADDR_W-1:0]        row_base;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   best_score;
    logic [CLS_W-1:0]          best_idx;

    assign start       = (state == IDLE) && image_ready && !image_ready_q;
    assign feed_active = (state == FEED) && image_ready;
    assign col_last    = (pix_col == COL_LAST);
    assign pix_last    = col_last && (pix_row == ROW_LAST);
    assign class_last  = (class_idx == CLS_LAST);

    // Incremental bases replace the class*R*C + row*C multiply.
    assign weight_addr = class_base + row_base + WADDR_W'(pix_col);
    assign mac_bit     = (state == FEED) && pix_bit;

`ifdef SKIP_ZERO_EN
    // A zero pixel contributes nothing, so it moves on without a MAC transaction.
    assign mac_valid = feed_active && pix_bit;
    assign advance   = feed_active && (!pix_bit || mac_ready);
`else
    assign mac_valid = feed_active;
    assign advance   = feed_active && mac_ready;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = FEED;
            FEED:    if (advance && pix_last) state_nxt = DRAIN;
            DRAIN:   if (acc_valid) state_nxt = COMPARE;
            COMPARE: state_nxt = class_last ? DONE : CLEAR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Dropping image_ready abandons the inference from any active state.
        if (state != IDLE && !image_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            image_ready_q <= 1'b0;
            pix_row       <= '0;
            pix_col       <= '0;
            class_idx     <= '0;
            class_base    <= '0;
            row_base      <= '0;
            acc_q         <= '0;
            best_score    <= ACC_MIN;
            best_idx      <= '0;
            mac_clear     <= 1'b0;
            busy          <= 1'b0;
            result_class  <= '0;
            result_score  <= '0;
            result_valid  <= 1'b0;
        end else begin
            state         <= state_nxt;
            image_ready_q <= image_ready;
            mac_clear     <= (state_nxt == CLEAR);
            busy          <= (state_nxt != IDLE);
            result_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        pix_row    <= '0;
                        pix_col    <= '0;
                        class_idx  <= '0;
                        class_base <= '0;
                        row_base   <= '0;
                        best_score <= ACC_MIN;
                        best_idx   <= '0;
                    end
                end

                FEED: begin
                    // The last pixel leaves the counters parked; COMPARE rewinds them.
                    if (advance && !pix_last) begin
                        if (col_last) begin
                            pix_col  <= '0;
                            pix_row  <= pix_row + 1'b1;
                            row_base <= row_base + COL_STEP;
                        end else begin
                            pix_col <= pix_col + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (acc_valid) begin
                        acc_q <= acc_in;
                    end
                end

                COMPARE: begin
                    // Strict greater-than so a tie keeps the lower class index.
                    if (acc_q > best_score) begin
                        best_score <= acc_q;
                        best_idx   <= class_idx;
                    end
                    if (!class_last) begin
                        class_idx  <= class_idx + 1'b1;
                        class_base <= class_base + CLASS_STEP;
                        pix_row    <= '0;
                        pix_col    <= '0;
                        row_base   <= '0;
                    end
                end

                DONE: begin
                    if (image_ready) begin
                        result_class <= best_idx;
                        result_score <= best_score;
                        result_valid <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule
